// File: rtl/ram_mp_pkg.sv
// rtl/ram_mp_pkg.sv - shared constants and helpers for the multi-port RAM
//
// Purpose: word/strobe widths, legal PORTS/LATENCY bounds and the port-id
// width helper used by ram_mp and its round-robin arbiter.
// Ports: none (package).
// Optional feature macro used by ram_mp: RAM_MP_MISALIGN_ERR_EN.

package ram_mp_pkg;

  localparam int WORD_W    = 32;
  localparam int BE_W      = 4;
  localparam int PORTS_MIN = 1;
  localparam int PORTS_MAX = 8;
  localparam int LAT_MIN   = 1;
  localparam int LAT_MAX   = 8;

  // A single port still needs a 1-bit id so vectors never collapse to zero width.
  function automatic int port_id_w(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

endpackage

// File: rtl/ram_mp_rr_arbiter.sv
// rtl/ram_mp_rr_arbiter.sv - N-wide round-robin arbiter with one-hot grant
//
// Purpose: grants at most one requester per cycle, searching upward from the
// pointer modulo N; the pointer moves to winner+1 on every grant.
// Ports:
//   clk      in  clock
//   rst      in  synchronous reset, active-high (pointer -> 0)
//   req_i    in  N   per-port request
//   gnt_o    out N   combinational one-hot grant (only to a requesting port)
//   gnt_id_o out IW  index of the granted port (0 when none)

module ram_mp_rr_arbiter
  import ram_mp_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = port_id_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_id_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] cand;
  logic          found;
  int            c_sum;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    cand     = '0;
    c_sum    = 0;
    for (int i = 0; i < N; i++) begin
      // Candidate index is ptr+i wrapped to N; N need not be a power of two.
      c_sum = int'(ptr_q) + i;
      if (c_sum >= N) c_sum = c_sum - N;
      cand = IW'(c_sum);
      if (!found && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        gnt_id_o    = cand;
        found       = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (gnt_id_o == IW'(N - 1)) ? '0 : gnt_id_o + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ram_mp.sv
// rtl/ram_mp.sv - multi-port word RAM with round-robin access and fixed latency
//
// Purpose: PORTS requesters share one 2^(WIDTH-2) x 32 array. One request is
// accepted per cycle (req & gnt); writes commit at the accept edge, reads
// sample at the accept edge, and every accepted request returns a one-cycle
// rvalid pulse LATENCY cycles later. Array contents are not reset.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   i_req   [PORTS]      request, held until granted
//   o_gnt   [PORTS]      combinational one-hot grant
//   i_we    [PORTS]      1 = write, 0 = read
//   i_be    [4*PORTS]    byte strobes, port p at [4p+3:4p]
//   i_addr  [WIDTH*PORTS] byte address, word index = addr[WIDTH-1:2]
//   i_data  [32*PORTS]   write data
//   o_rvalid[PORTS]      response pulse (reads and writes)
//   o_rdata [32*PORTS]   read data with o_rvalid, 0 for writes
//   o_err   [PORTS]      misalignment flag
// Optional: RAM_MP_MISALIGN_ERR_EN - nonzero addr[1:0] is flagged, the write
// is suppressed and the response carries o_err=1, o_rdata=0. Undefined:
// addr[1:0] is ignored and o_err stays 0.

module ram_mp
  import ram_mp_pkg::*;
#(
  parameter int WIDTH   = 12,
  parameter int PORTS   = 2,
  parameter int LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PORTS-1:0]        i_req,
  output logic [PORTS-1:0]        o_gnt,
  input  logic [PORTS-1:0]        i_we,
  input  logic [4*PORTS-1:0]      i_be,
  input  logic [WIDTH*PORTS-1:0]  i_addr,
  input  logic [32*PORTS-1:0]     i_data,
  output logic [PORTS-1:0]        o_rvalid,
  output logic [32*PORTS-1:0]     o_rdata,
  output logic [PORTS-1:0]        o_err
);

  localparam int AW    = WIDTH - 2;
  localparam int DEPTH = 1 << AW;
  localparam int PW    = port_id_w(PORTS);

  logic [PW-1:0]     gnt_id;
  logic              acc;
  logic              sel_we;
  logic [BE_W-1:0]   sel_be;
  logic [WIDTH-1:0]  sel_addr;
  logic [WORD_W-1:0] sel_data;
  logic [AW-1:0]     sel_word;
  logic              mis;
  logic              wr_en;
  logic [WORD_W-1:0] rd_word;

  logic [WORD_W-1:0] mem_q [DEPTH];

  logic [LATENCY-1:0] v_q, err_q;
  logic [PW-1:0]      id_q  [LATENCY];
  logic [WORD_W-1:0]  dat_q [LATENCY];
  logic [PORTS-1:0]   hit;

  ram_mp_rr_arbiter #(.N(PORTS)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    (i_req),
    .gnt_o    (o_gnt),
    .gnt_id_o (gnt_id)
  );

  assign acc = |o_gnt;

  // Route the winning port's request fields onto the shared array port.
  always_comb begin
    sel_we   = 1'b0;
    sel_be   = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (gnt_id == PW'(p)) begin
        sel_we   = i_we[p];
        sel_be   = i_be[p*BE_W +: BE_W];
        sel_addr = i_addr[p*WIDTH +: WIDTH];
        sel_data = i_data[p*WORD_W +: WORD_W];
      end
    end
  end

  assign sel_word = sel_addr[WIDTH-1:2];

`ifdef RAM_MP_MISALIGN_ERR_EN
  assign mis = acc & (|sel_addr[1:0]);
`else
  logic [1:0] unused_addr_lo;
  assign unused_addr_lo = sel_addr[1:0];
  assign mis = 1'b0;
`endif

  assign wr_en   = acc & sel_we & ~mis;
  assign rd_word = mem_q[sel_word];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (sel_be[b]) mem_q[sel_word][8*b +: 8] <= sel_data[8*b +: 8];
      end
    end
  end

  // Stage 0 captures the accept; the last stage drives the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      err_q <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        id_q[s]  <= '0;
        dat_q[s] <= '0;
      end
    end else begin
      v_q[0]   <= acc;
      err_q[0] <= mis;
      id_q[0]  <= gnt_id;
      dat_q[0] <= (acc & ~sel_we & ~mis) ? rd_word : '0;
      for (int s = 1; s < LATENCY; s++) begin
        v_q[s]   <= v_q[s-1];
        err_q[s] <= err_q[s-1];
        id_q[s]  <= id_q[s-1];
        dat_q[s] <= dat_q[s-1];
      end
    end
  end

  always_comb begin
    hit = '0;
    for (int p = 0; p < PORTS; p++) begin
      hit[p] = v_q[LATENCY-1] && (id_q[LATENCY-1] == PW'(p));
    end
  end

  always_comb begin
    o_rvalid = hit;
    o_rdata  = '0;
    o_err    = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (hit[p]) begin
        o_rdata[p*WORD_W +: WORD_W] = dat_q[LATENCY-1];
        o_err[p]                    = err_q[LATENCY-1];
      end
    end
  end

endmodule
